// File: rtl/micro_uart_pkg.sv
// Shared definitions for the micro UART receive controller: register map,
// status/control bit positions and the controller frame-tracking states.
package micro_uart_pkg;

  localparam logic [1:0] RX_DATA   = 2'd0;
  localparam logic [1:0] RX_STATUS = 2'd1;
  localparam logic [1:0] RX_COUNT  = 2'd2;
  localparam logic [1:0] RX_THRESH = 2'd3;

  localparam int ST_NONEMPTY = 0;
  localparam int ST_IRQ      = 1;
  localparam int ST_FULL     = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_RTS      = 5;

  localparam int CT_RX_ENA   = 0;
  localparam int CT_IRQ_ENA  = 1;
  localparam int CT_FLUSH    = 2;
  localparam int CT_CLR_OVR  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } rx_state_e;

endpackage

// File: rtl/micro_sync_fifo.sv
// Synchronous FIFO with registered read port; push/pop/flush arbitration only,
// overflow policy belongs to the instantiating controller.
module micro_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTHD = 8,
  localparam int WIDTHA = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              clock_sreset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WIDTHD-1:0] wdata,
  output logic [WIDTHD-1:0] rdata,
  output logic [WIDTHA:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [WIDTHA:0]   CNT_ONE = (WIDTHA+1)'(1);
  localparam logic [WIDTHA-1:0] PTR_ONE = WIDTHA'(1);

  logic [WIDTHD-1:0] mem_q [DEPTH];
  logic [WIDTHD-1:0] rdata_q;
  logic [WIDTHA-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTHA:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == (WIDTHA+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = rdata_q;

  // Flush wins over both ports; a full FIFO still accepts a push when a pop frees the slot.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
    if (do_pop)  rdata_q <= mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/micro_uart_rx_ctrl.sv
// CPU-facing receive controller: byte FIFO, 4-register bus port, level interrupt.
// Optional RTS flow control is enabled by defining MICRO_UART_RX_CTRL_RTS_EN.
module micro_uart_rx_ctrl
  import micro_uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic       clock,
  input  logic       clock_sreset,
  input  logic [1:0] addr,
  input  logic       wr_ena,
  input  logic       rd_ena,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_busy,
  output logic       enable_rxd,
  output logic       irq
`ifdef MICRO_UART_RX_CTRL_RTS_EN
  ,
  output logic       rts_n
`endif
);

  localparam int WIDTHA = $clog2(DEPTH);
  localparam logic [WIDTHA:0] THR_ONE   = (WIDTHA+1)'(1);
  localparam logic [WIDTHA:0] THR_DEPTH = (WIDTHA+1)'(DEPTH);

  function automatic logic [WIDTHA:0] clamp_thresh(input logic [WIDTHA:0] v);
    if (v == '0)       return THR_ONE;
    if (v > THR_DEPTH) return THR_DEPTH;
    return v;
  endfunction

  logic [7:0]      fifo_rdata;
  logic [WIDTHA:0] fifo_count;
  logic            fifo_full, fifo_empty;

  logic            rx_ena_q, rx_ena_d, irq_ena_q, irq_ena_d;
  logic            overrun_q, overrun_d, irq_q, irq_d;
  logic            sel_fifo_q, sel_fifo_d, busy_q;
  logic [WIDTHA:0] thresh_q, thresh_d;
  logic [7:0]      rd_data_q, rd_data_d, status;
  rx_state_e       state_q, state_d;

  logic wr_ctrl, flush, clr_ovr, pop_ok, ovr_set, unused_ok;

  assign wr_ctrl = wr_ena & (addr == RX_STATUS);
  assign flush   = wr_ctrl & wr_data[CT_FLUSH];
  assign clr_ovr = wr_ctrl & wr_data[CT_CLR_OVR];
  assign pop_ok  = rd_ena & (addr == RX_DATA) & ~fifo_empty & ~flush;
  assign ovr_set = rx_valid & fifo_full & ~pop_ok & ~flush;

  micro_sync_fifo #(
    .DEPTH  (DEPTH),
    .WIDTHD (8)
  ) u_fifo (
    .clock        (clock),
    .clock_sreset (clock_sreset),
    .push         (rx_valid),
    .pop          (pop_ok),
    .flush        (flush),
    .wdata        (rx_data),
    .rdata        (fifo_rdata),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

`ifdef MICRO_UART_RX_CTRL_RTS_EN
  logic rts_n_q, rts_n_d;
  assign rts_n_d   = ((DEPTH - int'(fifo_count)) <= RTS_MARGIN) | ~rx_ena_q;
  assign rts_n     = rts_n_q;
  assign unused_ok = ^wr_data;

  always_ff @(posedge clock) begin
    if (clock_sreset) rts_n_q <= 1'b1;
    else              rts_n_q <= rts_n_d;
  end
`else
  assign unused_ok = ^{wr_data, 1'(RTS_MARGIN)};
`endif

  always_comb begin
    status              = '0;
    status[ST_NONEMPTY] = ~fifo_empty;
    status[ST_IRQ]      = irq_q;
    status[ST_FULL]     = fifo_full;
    status[ST_OVERRUN]  = overrun_q;
    status[ST_BUSY]     = rx_busy;
`ifdef MICRO_UART_RX_CTRL_RTS_EN
    status[ST_RTS]      = ~rts_n_q;
`else
    status[ST_RTS]      = 1'b0;
`endif
  end

  always_comb begin
    rx_ena_d   = rx_ena_q;
    irq_ena_d  = irq_ena_q;
    overrun_d  = overrun_q;
    thresh_d   = thresh_q;
    rd_data_d  = rd_data_q;
    sel_fifo_d = sel_fifo_q;
    if (wr_ctrl) begin
      rx_ena_d  = wr_data[CT_RX_ENA];
      irq_ena_d = wr_data[CT_IRQ_ENA];
    end
    if (ovr_set)      overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
    if (wr_ena && addr == RX_THRESH) thresh_d = clamp_thresh(wr_data[WIDTHA:0]);
    // A popped head byte comes straight from the FIFO's read register next cycle.
    if (rd_ena) begin
      sel_fifo_d = pop_ok;
      unique case (addr)
        RX_DATA:   rd_data_d = 8'h00;
        RX_STATUS: rd_data_d = status;
        RX_COUNT:  rd_data_d = 8'(fifo_count);
        RX_THRESH: rd_data_d = 8'(thresh_q);
        default:   rd_data_d = 8'h00;
      endcase
    end
    irq_d = irq_ena_q & ((fifo_count >= thresh_q) | overrun_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx_busy && !busy_q) state_d = FRAME;
      FRAME:   if (rx_valid || (!rx_busy && busy_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      rx_ena_q   <= 1'b0;
      irq_ena_q  <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
      thresh_q   <= THR_ONE;
      rd_data_q  <= 8'h00;
      sel_fifo_q <= 1'b0;
      busy_q     <= 1'b0;
      state_q    <= IDLE;
    end else begin
      rx_ena_q   <= rx_ena_d;
      irq_ena_q  <= irq_ena_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      thresh_q   <= thresh_d;
      rd_data_q  <= rd_data_d;
      sel_fifo_q <= sel_fifo_d;
      busy_q     <= rx_busy;
      state_q    <= state_d;
    end
  end

  assign rd_data    = sel_fifo_q ? fifo_rdata : rd_data_q;
  assign enable_rxd = rx_ena_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_micro_uart_rx_ctrl.sv
// Scoreboard bench for micro_uart_rx_ctrl against a queue-based reference model.
module tb_micro_uart_rx_ctrl;

  localparam int DEPTH      = 16;
  localparam int RTS_MARGIN = 4;

  logic       clock = 1'b0;
  logic       clock_sreset;
  logic [1:0] addr;
  logic       wr_ena, rd_ena, rx_valid, rx_busy;
  logic [7:0] wr_data, rx_data, rd_data;
  logic       enable_rxd, irq;
`ifdef MICRO_UART_RX_CTRL_RTS_EN
  logic       rts_n;
`endif

  always #5 clock = ~clock;

  micro_uart_rx_ctrl #(
    .DEPTH      (DEPTH),
    .RTS_MARGIN (RTS_MARGIN)
  ) dut (
    .clock        (clock),
    .clock_sreset (clock_sreset),
    .addr         (addr),
    .wr_ena       (wr_ena),
    .rd_ena       (rd_ena),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .enable_rxd   (enable_rxd),
    .irq          (irq)
`ifdef MICRO_UART_RX_CTRL_RTS_EN
    ,
    .rts_n        (rts_n)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] fifo_m [$];
  logic [7:0] exp_q  [$];
  bit ovr_m, irq_m, rx_ena_m, irq_ena_m, rts_m;
  int thresh_m;

  task automatic check_eq(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a read issued at a rising edge is answered before the next one.
  bit rd_seen = 1'b0;
  always @(posedge clock) rd_seen <= rd_ena & ~clock_sreset;

  always @(negedge clock) begin
    if (rd_seen) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_data: got %02h with no expected entry at %0t", rd_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_bad++;
          $display("FAIL rd_data: got %02h expected %02h at %0t", rd_data, e, $time);
        end
      end
    end
  end

  task automatic model_reset();
    fifo_m.delete();
    ovr_m = 0; irq_m = 0; rx_ena_m = 0; irq_ena_m = 0; rts_m = 1; thresh_m = 1;
  endtask

  task automatic check_levels();
    check_eq("irq", 8'(irq), 8'(irq_m));
    check_eq("enable_rxd", 8'(enable_rxd), 8'(rx_ena_m));
`ifdef MICRO_UART_RX_CTRL_RTS_EN
    check_eq("rts_n", 8'(rts_n), 8'(rts_m));
`endif
  endtask

  // One bus/receiver cycle: inputs applied now, model advanced to the post-edge state.
  task automatic drive(input bit rd, input bit wr, input logic [1:0] a, input logic [7:0] wd,
                       input bit rv, input logic [7:0] rb);
    int sz, tv;
    bit flush, popped, ovr_set, irq_n, rts_nx, rts_bit;
    logic [7:0] e;
    sz      = fifo_m.size();
    flush   = wr && a == 2'd1 && wd[2];
    popped  = rd && a == 2'd0 && !flush && sz > 0;
    irq_n   = irq_ena_m && (sz >= thresh_m || ovr_m);
    rts_nx  = ((DEPTH - sz) <= RTS_MARGIN) || !rx_ena_m;
`ifdef MICRO_UART_RX_CTRL_RTS_EN
    rts_bit = !rts_m;
`else
    rts_bit = 1'b0;
`endif
    if (rd) begin
      case (a)
        2'd0:    e = popped ? fifo_m[0] : 8'h00;
        2'd1:    e = {2'b00, rts_bit, rx_busy, ovr_m, (sz == DEPTH), irq_m, (sz != 0)};
        2'd2:    e = 8'(sz);
        default: e = 8'(thresh_m);
      endcase
      exp_q.push_back(e);
    end
    addr = a; rd_ena = rd; wr_ena = wr; wr_data = wd; rx_valid = rv; rx_data = rb;

    ovr_set = 0;
    if (popped) void'(fifo_m.pop_front());
    if (rv && !flush) begin
      if (fifo_m.size() < DEPTH) fifo_m.push_back(rb);
      else ovr_set = 1;
    end
    if (flush) fifo_m.delete();
    if (wr && a == 2'd1) begin
      rx_ena_m  = wd[0];
      irq_ena_m = wd[1];
      if (wd[3]) ovr_m = 0;
    end
    if (ovr_set) ovr_m = 1;
    if (wr && a == 2'd3) begin
      tv = int'(wd) % (2 * DEPTH);
      if (tv == 0) tv = 1;
      else if (tv > DEPTH) tv = DEPTH;
      thresh_m = tv;
    end
    irq_m = irq_n;
    rts_m = rts_nx;

    @(posedge clock); #1;
    rd_ena = 0; wr_ena = 0; rx_valid = 0;
    check_levels();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 2'd0, 8'h00, 0, 8'h00);
  endtask

  task automatic push(input logic [7:0] b);
    drive(0, 0, 2'd0, 8'h00, 1, b);
  endtask

  task automatic rd(input logic [1:0] a);
    drive(1, 0, a, 8'h00, 0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    drive(0, 1, a, d, 0, 8'h00);
  endtask

  task automatic apply_reset(input int n);
    clock_sreset = 1;
    addr = 0; rd_ena = 0; wr_ena = 0; wr_data = 0; rx_valid = 0; rx_data = 0; rx_busy = 0;
    repeat (n) @(posedge clock);
    #1;
    clock_sreset = 0;
    model_reset();
    check_eq("reset rd_data", rd_data, 8'h00);
    check_levels();
  endtask

  initial begin
    model_reset();
    @(posedge clock); #1;
    apply_reset(3);
    rd(2'd2); rd(2'd3); rd(2'd1); rd(2'd0);

    // Two bytes in, read back in order
    wr(2'd1, 8'h03);
    push(8'h41); push(8'h42);
    rd(2'd2); rd(2'd1); rd(2'd0); rd(2'd0); rd(2'd1); rd(2'd0);

    // Threshold interrupt rises and falls
    wr(2'd3, 8'h03);
    push(8'h10); push(8'h11); push(8'h12);
    idle(2);
    rd(2'd0);
    idle(2);
    rd(2'd0); rd(2'd0);

    // Overrun on the 17th byte, then clear it
    for (int i = 0; i < DEPTH + 1; i++) push(8'(8'h60 + i));
    rd(2'd2); rd(2'd1); idle(1);
    wr(2'd1, 8'h0B);
    rd(2'd1);
    // Full FIFO with coincident push and pop
    drive(1, 0, 2'd0, 8'h00, 1, 8'hA5);
    rd(2'd2); rd(2'd1);
    for (int i = 0; i < DEPTH + 1; i++) rd(2'd0);

    // Flush together with an incoming byte
    push(8'h33); push(8'h34);
    drive(0, 1, 2'd1, 8'h07, 1, 8'h55);
    rd(2'd2); rd(2'd0); rd(2'd1);

    // Flow-control watermark
    for (int i = 0; i < 12; i++) push(8'(i));
    idle(1);
    rd(2'd1);
    rd(2'd0);
    idle(1);
    rd(2'd1);
    wr(2'd1, 8'h07);

    // Threshold clamping and simultaneous read/write
    wr(2'd3, 8'h00); rd(2'd3);
    wr(2'd3, 8'hFF); rd(2'd3);
    wr(2'd3, 8'h25); rd(2'd3);
    drive(1, 1, 2'd1, 8'h03, 0, 8'h00);
    drive(1, 1, 2'd3, 8'h02, 0, 8'h00);
    rd(2'd3);

    // Mid-operation reset
    push(8'hC3); push(8'hC4);
    wr(2'd1, 8'h03);
    rd(2'd0);
    apply_reset(1);
    rd(2'd2); rd(2'd1); rd(2'd3);

    // Randomized traffic
    wr(2'd1, 8'h03);
    for (int i = 0; i < 800; i++) begin
      int r;
      bit rv;
      logic [7:0] b, c;
      r  = $urandom_range(0, 99);
      rv = ($urandom_range(0, 99) < 45);
      b  = 8'($urandom);
      rx_busy = ($urandom_range(0, 3) == 0);
      c = {4'b0000, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0)};
      if (r < 35)      drive(1, 0, 2'd0, 8'h00, rv, b);
      else if (r < 45) drive(1, 0, 2'($urandom_range(1, 3)), 8'h00, rv, b);
      else if (r < 49) drive(0, 1, 2'd1, c, rv, b);
      else if (r < 52) drive(0, 1, 2'd3, 8'($urandom_range(0, 40)), rv, b);
      else if (r < 54) drive(1, 1, 2'd1, c, rv, b);
      else             drive(0, 0, 2'd0, 8'h00, rv, b);
    end
    rx_busy = 0;
    idle(1);
    @(negedge clock); #1;
    check_eq("scoreboard drained", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
